// File: rtl/sext_stream.sv
// sext_stream: streaming sign/zero/ones extender with a 2-entry output FIFO.
//
// Each accepted IN_W-bit sample is extended to OUT_W bits around a per-sample
// sign position (in_msb, clamped to IN_W-1) using the fill selected by in_mode.
// The extended word is stored at acceptance and presented from the FIFO head.
//
// Ports:
//   clk, areset           clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake; in_ready depends only on occupancy
//   in_data/in_msb/in_mode raw sample, sign-bit index, fill mode (00/11 sign, 01 zero, 10 ones)
//   out_valid/out_ready   output handshake
//   out_data              oldest stored extended sample
//   out_count             completed output transfers, saturating
module sext_stream #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned MSB_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [MSB_W-1:0] in_msb,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [MSB_W-1:0] MaxMsb = MSB_W'(IN_W - 1);

  logic [OUT_W-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push, pop;
  logic [MSB_W-1:0] msb_eff;
  logic             fill;
  logic [OUT_W-1:0] ext;

  // Extension of the current input sample
  always_comb begin
    msb_eff = (in_msb > MaxMsb) ? MaxMsb : in_msb;
    unique case (in_mode)
      2'b01:   fill = 1'b0;
      2'b10:   fill = 1'b1;
      default: fill = in_data[msb_eff];
    endcase
    ext = {OUT_W{fill}};
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (i <= 32'(msb_eff)) ext[i] = in_data[i];
    end
  end

  // Handshakes depend on registered occupancy only
  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (pop && (count_q != {CNT_W{1'b1}})) count_d = count_q + 1'b1;
  end

  assign out_count = count_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= ext;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q   <= occ_d;
      count_q <= count_d;
    end
  end

endmodule
